tile_pixel_mixer: RTL and testbench

TILE_PIXEL_MIXER -- requirements
Module: tile_pixel_mixer

---
 rtl/tmnt_pkg.sv | 46 ++++
 rtl/tile_prio_sel.sv | 66 ++++++
 rtl/tile_pixel_mixer.sv | 120 ++++++++++++
 tb/tb_tile_pixel_mixer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmnt_pkg.sv
// Shared types and constants for the tile/sprite pixel mixer.
// SRC tags, control-register reset value and the clear-pixel nibble.
package tmnt_pkg;

    typedef enum logic [2:0] {
        SRC_BACK = 3'd0,
        SRC_FIX  = 3'd1,
        SRC_A    = 3'd2,
        SRC_B    = 3'd3,
        SRC_OBJ  = 3'd4
    } src_e;

    // Control: [0] PRIO, [1] A en, [2] B en, [3] FIX en
    localparam logic [3:0] CTRL_RST  = 4'b1110;
    localparam logic [3:0] PIX_CLEAR = 4'h0;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] obj;
        logic [7:0]  fix;
        logic        t_a;
        logic        t_b;
        logic        t_fix;
        logic        t_obj;
        logic        obj_pri;
        logic        prio;
        logic        nblk;
    } st1_t;

    localparam st1_t ST1_RST = '{
        a: 12'h000, b: 12'h000, obj: 12'h000,
        fix: 8'h00,
        t_a: 1'b1, t_b: 1'b1,
        t_fix: 1'b1, t_obj: 1'b1,
        obj_pri: 1'b0, prio: 1'b0,
        nblk: 1'b0
    };

    function automatic logic is_clear(
        input logic [3:0] pix
    );
        return pix == PIX_CLEAR;
    endfunction

endpackage

// File: rtl/tile_prio_sel.sv
// Combinational layer ranking: picks the highest opaque candidate.
// Order: FIX > OBJ(pri=0) > first > OBJ(pri=1) > second, PRIO swaps A/B.
module tile_prio_sel
    import tmnt_pkg::*;
(
    input  logic [11:0] back_i,
    input  logic [11:0] fix_i,
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    input  logic [11:0] obj_i,
    input  logic        t_fix_i,
    input  logic        t_a_i,
    input  logic        t_b_i,
    input  logic        t_obj_i,
    input  logic        prio_i,
    input  logic        obj_pri_i,
    output logic [11:0] col_o,
    output src_e        src_o
);

    logic [11:0] hi_code;
    logic [11:0] lo_code;
    logic        hi_t;
    logic        lo_t;
    src_e        hi_src;
    src_e        lo_src;

    always_comb begin
        hi_code = a_i;
        hi_t    = t_a_i;
        hi_src  = SRC_A;
        lo_code = b_i;
        lo_t    = t_b_i;
        lo_src  = SRC_B;
        if (prio_i) begin
            hi_code = b_i;
            hi_t    = t_b_i;
            hi_src  = SRC_B;
            lo_code = a_i;
            lo_t    = t_a_i;
            lo_src  = SRC_A;
        end
    end

    always_comb begin
        col_o = back_i;
        src_o = SRC_BACK;
        if (!t_fix_i) begin
            col_o = fix_i;
            src_o = SRC_FIX;
        end else if (!t_obj_i && !obj_pri_i) begin
            col_o = obj_i;
            src_o = SRC_OBJ;
        end else if (!hi_t) begin
            col_o = hi_code;
            src_o = hi_src;
        end else if (!t_obj_i && obj_pri_i) begin
            col_o = obj_i;
            src_o = SRC_OBJ;
        end else if (!lo_t) begin
            col_o = lo_code;
            src_o = lo_src;
        end
    end

endmodule

// File: rtl/tile_pixel_mixer.sv
// Two-stage pixel mixer with vblank-deferred control register.
// Sprite layer participates only when OBJ_LAYER_EN is defined.
module tile_pixel_mixer
    import tmnt_pkg::*;
(
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        ce_6M,
    input  logic [11:0] DSA,
    input  logic [11:0] DSB,
    input  logic [7:0]  DFI,
    input  logic [11:0] OBJ,
    input  logic        OBJ_PRI,
    input  logic        NBLK,
    input  logic        NVBL,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_din,
    output logic [11:0] COL,
    output logic [2:0]  SRC
);

    logic [3:0]  pend_q, pend_d;
    logic [3:0]  act_q, act_d;
    logic        nvbl_q;
    logic        vbl_fall;
    st1_t        s1_q, s1_d;
    logic [11:0] col_q, col_d;
    src_e        src_q, src_d;
    logic [11:0] sel_col;
    src_e        sel_src;
    logic        obj_clear;

    assign vbl_fall = nvbl_q & ~NVBL;

    // A write on the fall edge goes straight through to active.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (cpu_wr) begin
            pend_d = cpu_din;
        end
        if (vbl_fall) begin
            act_d = pend_d;
        end
    end

`ifdef OBJ_LAYER_EN
    assign obj_clear = is_clear(OBJ[3:0]);
`else
    assign obj_clear = 1'b1;
`endif

    always_comb begin
        s1_d = s1_q;
        if (ce_6M) begin
            s1_d.a       = DSA;
            s1_d.b       = DSB;
            s1_d.obj     = OBJ;
            s1_d.fix     = DFI;
            s1_d.t_a     = is_clear(DSA[3:0]) | ~act_q[1];
            s1_d.t_b     = is_clear(DSB[3:0]) | ~act_q[2];
            s1_d.t_fix   = is_clear(DFI[3:0]) | ~act_q[3];
            s1_d.t_obj   = obj_clear;
            s1_d.obj_pri = OBJ_PRI;
            s1_d.prio    = act_q[0];
            s1_d.nblk    = NBLK;
        end
    end

    tile_prio_sel u_sel (
        .back_i    (12'h000),
        .fix_i     ({4'h0, s1_q.fix}),
        .a_i       (s1_q.a),
        .b_i       (s1_q.b),
        .obj_i     (s1_q.obj),
        .t_fix_i   (s1_q.t_fix),
        .t_a_i     (s1_q.t_a),
        .t_b_i     (s1_q.t_b),
        .t_obj_i   (s1_q.t_obj),
        .prio_i    (s1_q.prio),
        .obj_pri_i (s1_q.obj_pri),
        .col_o     (sel_col),
        .src_o     (sel_src)
    );

    always_comb begin
        col_d = col_q;
        src_d = src_q;
        if (ce_6M) begin
            col_d = 12'h000;
            src_d = SRC_BACK;
            if (s1_q.nblk) begin
                col_d = sel_col;
                src_d = sel_src;
            end
        end
    end

    always_ff @(posedge clk_24M) begin
        if (rst) begin
            pend_q <= CTRL_RST;
            act_q  <= CTRL_RST;
            nvbl_q <= 1'b0;
            s1_q   <= ST1_RST;
            col_q  <= 12'h000;
            src_q  <= SRC_BACK;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            nvbl_q <= NVBL;
            s1_q   <= s1_d;
            col_q  <= col_d;
            src_q  <= src_d;
        end
    end

    assign COL = col_q;
    assign SRC = src_q;

endmodule

// File: tb/tb_tile_pixel_mixer.sv
// Scoreboard bench for tile_pixel_mixer against a ranking model.
// Honours OBJ_LAYER_EN in the reference model.
module tb_tile_pixel_mixer;
    import tmnt_pkg::*;

    logic        clk_24M = 1'b0;
    logic        rst     = 1'b1;
    logic        ce_6M   = 1'b0;
    logic [11:0] DSA     = 12'h000;
    logic [11:0] DSB     = 12'h000;
    logic [7:0]  DFI     = 8'h00;
    logic [11:0] OBJ     = 12'h000;
    logic        OBJ_PRI = 1'b0;
    logic        NBLK    = 1'b1;
    logic        NVBL    = 1'b1;
    logic        cpu_wr  = 1'b0;
    logic [3:0]  cpu_din = 4'h0;
    logic [11:0] COL;
    logic [2:0]  SRC;

    int n_chk  = 0;
    int n_fail = 0;
    int phase  = 0;

    logic [14:0] expq[$];
    logic [14:0] hold_exp = 15'h0;
    logic [3:0]  m_pend   = 4'b1110;
    logic [3:0]  m_act    = 4'b1110;
    logic        m_nv     = 1'b0;

    tile_pixel_mixer dut (
        .clk_24M (clk_24M),
        .rst     (rst),
        .ce_6M   (ce_6M),
        .DSA     (DSA),
        .DSB     (DSB),
        .DFI     (DFI),
        .OBJ     (OBJ),
        .OBJ_PRI (OBJ_PRI),
        .NBLK    (NBLK),
        .NVBL    (NVBL),
        .cpu_wr  (cpu_wr),
        .cpu_din (cpu_din),
        .COL     (COL),
        .SRC     (SRC)
    );

    always #5 clk_24M = ~clk_24M;

    task automatic check(
        input string       name,
        input logic [14:0] act,
        input logic [14:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got src=%0d col=%03h want src=%0d col=%03h",
                     name, act[14:12], act[11:0], exp[14:12], exp[11:0]);
        end
    endtask

    // Returns {src, col}: walk sources in rank order, first visible wins.
    function automatic logic [14:0] ref_pix(
        input logic [11:0] a,
        input logic [11:0] b,
        input logic [11:0] obj,
        input logic [7:0]  fx,
        input logic        opri,
        input logic        nblk,
        input logic [3:0]  ctl
    );
        logic [11:0] code[5];
        logic [2:0]  tag[5];
        logic        vis[5];
        logic        objv;
        logic        av;
        logic        bv;
        if (!nblk) return 15'h0;
`ifdef OBJ_LAYER_EN
        objv = (obj[3:0] != 4'h0);
`else
        objv = 1'b0;
`endif
        av = ctl[1] && (a[3:0] != 4'h0);
        bv = ctl[2] && (b[3:0] != 4'h0);
        code[0] = {4'h0, fx};
        tag[0]  = 3'd1;
        vis[0]  = ctl[3] && (fx[3:0] != 4'h0);
        code[1] = obj;
        tag[1]  = 3'd4;
        vis[1]  = objv && !opri;
        code[2] = ctl[0] ? b : a;
        tag[2]  = ctl[0] ? 3'd3 : 3'd2;
        vis[2]  = ctl[0] ? bv : av;
        code[3] = obj;
        tag[3]  = 3'd4;
        vis[3]  = objv && opri;
        code[4] = ctl[0] ? a : b;
        tag[4]  = ctl[0] ? 3'd2 : 3'd3;
        vis[4]  = ctl[0] ? av : bv;
        for (int i = 0; i < 5; i++) begin
            if (vis[i]) return {tag[i], code[i]};
        end
        return 15'h0;
    endfunction

    task automatic tick();
        logic [14:0] e;
        logic        smp;
        logic        was_rst;
        e = 15'h0;
        @(posedge clk_24M);
        smp     = ce_6M && !rst;
        was_rst = rst;
        if (smp) e = ref_pix(DSA, DSB, OBJ, DFI,
                             OBJ_PRI, NBLK, m_act);
        if (rst) begin
            m_pend = 4'b1110;
            m_act  = 4'b1110;
            m_nv   = 1'b0;
        end else begin
            if (cpu_wr) m_pend = cpu_din;
            if (m_nv && !NVBL) m_act = m_pend;
            m_nv = NVBL;
        end
        @(negedge clk_24M);
        if (was_rst) expq.delete();
        if (smp) expq.push_back(e);
        check("ctrl", {11'h0, dut.act_q}, {11'h0, m_act});
        phase = (phase + 1) % 4;
        ce_6M = (phase == 0);
    endtask

    task automatic pix(
        input logic [11:0] a,
        input logic [11:0] b,
        input logic [7:0]  fx,
        input logic [11:0] o,
        input logic        op,
        input logic        nb
    );
        DSA     = a;
        DSB     = b;
        DFI     = fx;
        OBJ     = o;
        OBJ_PRI = op;
        NBLK    = nb;
        repeat (4) tick();
    endtask

    task automatic wr(input logic [3:0] d);
        cpu_wr  = 1'b1;
        cpu_din = d;
        tick();
        cpu_wr  = 1'b0;
    endtask

    task automatic vbl();
        NVBL = 1'b0;
        repeat (3) tick();
        NVBL = 1'b1;
        tick();
    endtask

    function automatic logic [3:0] rnib();
        if ($urandom_range(0, 2) == 0) return 4'h0;
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin : monitor
        forever begin
            @(posedge clk_24M);
            #1;
            if (rst) begin
                hold_exp = 15'h0;
                check("reset", {SRC, COL}, 15'h0);
            end else if (ce_6M) begin
                hold_exp = (expq.size() > 0) ?
                           expq.pop_front() : 15'h0;
                check("pix", {SRC, COL}, hold_exp);
            end else begin
                check("hold", {SRC, COL}, hold_exp);
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        repeat (6) tick();
        rst = 1'b0;
        repeat (3) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        repeat (2) pix(12'h125, 12'h3A7, 8'h43, 12'h000, 1'b0, 1'b1);
        repeat (2) pix(12'h120, 12'h340, 8'h50, 12'h000, 1'b0, 1'b1);
        repeat (2) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b0);
        pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        wr(4'b1111);
        repeat (3) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        vbl();
        repeat (3) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        wr(4'b0110);
        wr(4'b1110);
        vbl();
        repeat (2) pix(12'h125, 12'h3A7, 8'h43, 12'h000, 1'b0, 1'b1);
        NVBL    = 1'b0;
        cpu_wr  = 1'b1;
        cpu_din = 4'b1011;
        tick();
        cpu_wr  = 1'b0;
        repeat (2) tick();
        NVBL = 1'b1;
        repeat (2) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        wr(4'b1110);
        vbl();
        repeat (2) pix(12'h125, 12'h3A7, 8'h00, 12'h2F1, 1'b1, 1'b1);
        repeat (2) pix(12'h120, 12'h3A7, 8'h00, 12'h2F1, 1'b1, 1'b1);
        repeat (2) pix(12'h125, 12'h3A7, 8'h00, 12'h2F1, 1'b0, 1'b1);
        wr(4'b0101);
        vbl();
        DSA = 12'h125;
        repeat (6) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) pix(12'h125, 12'h3A7, 8'h00, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            DSA     = {8'($urandom), rnib()};
            DSB     = {8'($urandom), rnib()};
            DFI     = {4'($urandom), rnib()};
            OBJ     = {8'($urandom), rnib()};
            OBJ_PRI = 1'($urandom);
            NBLK    = ($urandom_range(0, 9) != 0);
            cpu_wr  = ($urandom_range(0, 11) == 0);
            cpu_din = 4'($urandom);
            if ($urandom_range(0, 15) == 0) NVBL = ~NVBL;
            tick();
            cpu_wr = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
        end
        NVBL = 1'b1;
        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
